// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: central timing for the game. Produces a free-running
// pixel enable and a game-step tick as single-cycle enables on clk. The step
// period shrinks as speed levels rise. A run/pause/over state machine gates
// the step tick, and its state is exposed on the state output.
//
// Control handshake: start, pause_toggle and crash are one-cycle request
// pulses with implicit valid (high for one clk). There is no ready; a pulse
// that does not apply in the current state is dropped, not queued.
module game_tick_scheduler #(
    parameter int PIX_DIV     = 4,
    parameter int STEP_INIT   = 1666666,
    parameter int STEP_MIN    = 416666,
    parameter int STEP_DEC    = 20000,
    parameter int LEVEL_STEPS = 512,
    parameter int CW          = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause_toggle,
    input  logic          crash,
    output logic          pix_en,
    output logic          step_tick,
    output logic [1:0]    state,
    output logic [3:0]    speed_level,
    output logic [CW-1:0] step_period
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    localparam int PW = $clog2(PIX_DIV);
    localparam int LW = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;

    localparam logic [PW-1:0] PIX_LAST    = PW'(PIX_DIV - 1);
    localparam logic [LW-1:0] LVL_LAST    = LW'(LEVEL_STEPS - 1);
    localparam logic [CW-1:0] PERIOD_INIT = CW'(STEP_INIT);
    localparam logic [CW-1:0] PERIOD_MIN  = CW'(STEP_MIN);
    localparam logic [CW-1:0] PERIOD_DEC  = CW'(STEP_DEC);
    // Threshold at CW+1 bits so STEP_MIN+STEP_DEC cannot wrap.
    localparam logic [CW:0]   DEC_FLOOR   = (CW+1)'(STEP_MIN) + (CW+1)'(STEP_DEC);

    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] step_cnt;
    logic [LW-1:0] lvl_cnt;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          new_game;
    logic          leave_run;
    logic          count_en;
    logic          at_term;
    logic          issue_tick;
    logic          lvl_wrap;
    logic [CW-1:0] period_next;

    assign state = state_q;

    // Next-state decode; crash has priority over pause_toggle in RUN.
    always_comb begin
        state_d   = state_q;
        new_game  = 1'b0;
        leave_run = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    new_game = 1'b1;
                end
            end
            S_RUN: begin
                if (crash) begin
                    state_d   = S_OVER;
                    leave_run = 1'b1;
                end else if (pause_toggle) begin
                    state_d   = S_PAUSED;
                    leave_run = 1'b1;
                end
            end
            S_PAUSED: begin
                if (pause_toggle) begin
                    state_d = S_RUN;
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d  = S_RUN;
                    new_game = 1'b1;
                end
            end
        endcase
    end

    // Step-count qualifiers and the next (decremented, floored) period.
    always_comb begin
        count_en    = (state_q == S_RUN) && !leave_run;
        at_term     = (step_cnt == (step_period - CW'(1)));
        issue_tick  = count_en && at_term;
        lvl_wrap    = (lvl_cnt == LVL_LAST);
        period_next = ({1'b0, step_period} >= DEC_FLOOR) ? (step_period - PERIOD_DEC)
                                                          : PERIOD_MIN;
    end

    // Free-running pixel divider; pix_en follows the terminal count by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en <= (pix_cnt == PIX_LAST);
            if (pix_cnt == PIX_LAST) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + PW'(1);
            end
        end
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step counter and tick; counter freezes outside RUN and on exit edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            if (new_game) begin
                step_cnt <= '0;
            end else if (count_en) begin
                if (at_term) begin
                    step_cnt  <= '0;
                    step_tick <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + CW'(1);
                end
            end
        end
    end

    // Speed ramp: every LEVEL_STEPS ticks raise the level and shorten the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_cnt     <= '0;
            speed_level <= 4'd0;
            step_period <= PERIOD_INIT;
        end else if (new_game) begin
            lvl_cnt     <= '0;
            speed_level <= 4'd0;
            step_period <= PERIOD_INIT;
        end else if (issue_tick) begin
            if (lvl_wrap) begin
                lvl_cnt <= '0;
                if (speed_level != 4'd15) begin
                    speed_level <= speed_level + 4'd1;
                    step_period <= period_next;
                end
            end else begin
                lvl_cnt <= lvl_cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a small, fast parameter set.
module tb_game_tick_scheduler;

    localparam int CW = 24;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pause_toggle = 1'b0;
    logic          crash = 1'b0;
    logic          pix_en;
    logic          step_tick;
    logic [1:0]    state;
    logic [3:0]    speed_level;
    logic [CW-1:0] step_period;

    game_tick_scheduler #(
        .PIX_DIV     (4),
        .STEP_INIT   (10),
        .STEP_MIN    (4),
        .STEP_DEC    (3),
        .LEVEL_STEPS (2),
        .CW          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause_toggle (pause_toggle),
        .crash        (crash),
        .pix_en       (pix_en),
        .step_tick    (step_tick),
        .state        (state),
        .speed_level  (speed_level),
        .step_period  (step_period)
    );

    // scoreboard: expected tick spacings, hand computed
    logic [31:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks: one edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
    endtask

    task automatic pulse_crash();
        crash = 1'b1; step(); crash = 1'b0;
    endtask

    // edges until step_tick is seen, bounded at 200
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (step_tick !== 1'b1 && n < 200);
    endtask

    // run n edges and count step_tick pulses
    task automatic count_ticks(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (step_tick === 1'b1) ticks++;
        end
    endtask

    task automatic expect_spacings(input int cnt);
        int n;
        for (int i = 0; i < cnt; i++) begin
            wait_tick(n);
            check("tick_spacing", n, exp_q.pop_front());
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int ticks;
        int pix_bad;
        int st_bad;

        // reset state
        rst = 1'b1;
        step(); step();
        check("rst_pix_en", pix_en, 0);
        check("rst_step_tick", step_tick, 0);
        check("rst_state", state, 0);
        check("rst_level", speed_level, 0);
        check("rst_period", step_period, 10);
        rst = 1'b0;

        // 1: idle for 100 edges, pix_en on every 4th edge, no ticks
        pix_bad = 0; st_bad = 0; ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (pix_en !== ((k % 4) == 0)) pix_bad++;
            if (step_tick === 1'b1) ticks++;
            if (state !== 2'd0) st_bad++;
        end
        check("idle_pix_pattern_errors", pix_bad, 0);
        check("idle_ticks", ticks, 0);
        check("idle_state_errors", st_bad, 0);
        pulse_pause();
        check("idle_ignores_pause", state, 0);
        pulse_crash();
        check("idle_ignores_crash", state, 0);

        // 2: start, first tick after 10 edges, then every 10
        pulse_start();
        check("start_state", state, 1);
        check("start_period", step_period, 10);
        check("start_level", speed_level, 0);
        wait_tick(n);
        check("first_tick_edges", n, 10);
        step();
        check("tick_one_cycle", step_tick, 0);
        wait_tick(n);
        check("second_tick_edges", n, 9);
        check("lvl1_period", step_period, 7);
        check("lvl1_level", speed_level, 1);

        // 3: ramp 7,7 then 4,4 then floor
        exp_q.push_back(7); exp_q.push_back(7);
        expect_spacings(2);
        check("lvl2_period", step_period, 4);
        check("lvl2_level", speed_level, 2);
        exp_q.push_back(4); exp_q.push_back(4);
        expect_spacings(2);
        check("lvl3_period", step_period, 4);
        check("lvl3_level", speed_level, 3);
        exp_q.push_back(4);
        expect_spacings(1);
        check("lvl3_hold_period", step_period, 4);

        // 5: crash+pause together at terminal count
        step(); step(); step();
        crash = 1'b1; pause_toggle = 1'b1;
        step();
        crash = 1'b0; pause_toggle = 1'b0;
        check("crash_state", state, 3);
        check("crash_no_tick", step_tick, 0);
        check("over_level", speed_level, 3);
        check("over_period", step_period, 4);
        count_ticks(20, ticks);
        check("over_ticks", ticks, 0);
        pulse_pause();
        check("over_ignores_pause", state, 3);
        pulse_start();
        check("restart_state", state, 1);
        check("restart_period", step_period, 10);
        check("restart_level", speed_level, 0);
        wait_tick(n);
        check("restart_first_tick", n, 10);

        // 4: pause after 5 RUN edges of a count, resume, tick on 5th edge
        pulse_start();
        check("run_ignores_start", state, 1);
        step(); step(); step(); step();
        pulse_pause();
        check("pause_state", state, 2);
        count_ticks(20, ticks);
        pulse_crash();
        check("paused_ignores_crash", state, 2);
        pulse_start();
        check("paused_ignores_start", state, 2);
        count_ticks(28, n);
        check("paused_ticks", ticks + n, 0);
        pulse_pause();
        check("resume_state", state, 1);
        wait_tick(n);
        check("resume_tick_edges", n, 5);
        check("g2_lvl1_period", step_period, 7);
        check("g2_lvl1_level", speed_level, 1);
        exp_q.push_back(7); exp_q.push_back(7);
        expect_spacings(2);
        check("g2_lvl2_level", speed_level, 2);
        check("g2_lvl2_period", step_period, 4);

        // pause at terminal count: tick held, issued on first RUN edge after resume
        step(); step(); step();
        pulse_pause();
        check("term_pause_state", state, 2);
        check("term_pause_no_tick", step_tick, 0);
        pulse_pause();
        check("term_resume_no_tick", step_tick, 0);
        wait_tick(n);
        check("term_resume_tick_edges", n, 1);
        check("term_resume_level", speed_level, 2);

        // 6: reset mid-RUN
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_period", step_period, 10);
        check("mid_rst_level", speed_level, 0);
        check("mid_rst_tick", step_tick, 0);
        check("mid_rst_pix_en", pix_en, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (pix_en !== 1'b1 && n < 50);
        check("mid_rst_first_pix", n, 4);
        count_ticks(30, ticks);
        check("mid_rst_no_ticks", ticks, 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
